tx_iq_buf: RTL and testbench
============================

TX_IQ_BUF -- requirements
Module: tx_iq_buf

Interface
REQ-001 Parameter DEPTH, default 64, FIFO depth in IQ samples (power of two).
REQ-002 Parameter HOLD_MARGIN, default 4, free entries kept for samples already in the producer pipeline when hold rises.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 phy_tx_arestn  input  1  reset, asynchronous, active-low.
REQ-005 phy_tx_start  input  1  one-cycle pulse starting a packet.
REQ-006 phy_tx_done  input  1  one-cycle pulse: producer has emitted its last sample.
REQ-007 result_iq_valid  input  1  producer sample strobe.
REQ-008 result_i, result_q  input  16 each  producer sample, signed.
REQ-009 result_iq_hold  output  1  backpressure to producer.
REQ-010 rate_div  input  8  clocks per DAC sample; values 0 and 1 both mean every clock.
REQ-011 prefill_thresh  input  7  FIFO level required before streaming starts.
REQ-012 dac_valid  output  1  one-cycle strobe per output sample.
REQ-013 dac_i, dac_q  output  16 each  output sample.
REQ-014 fifo_level  output  7  current occupancy, 0..DEPTH.
REQ-015 underrun, overflow  output  1 each  sticky error flags, cleared by phy_tx_start.
REQ-016 tx_iq_done  output  1  one-cycle pulse when the last sample has left.

Function
REQ-017 Write: on result_iq_valid with FIFO not full, store {i,q}; level +1.
REQ-018 Write when full: drop the sample, set overflow, leave level unchanged.
REQ-019 Read: on a tick in STREAM with level>0; level -1.
REQ-020 Simultaneous read and write: level unchanged; pointers wrap modulo DEPTH.
REQ-021 result_iq_hold is registered: high the cycle after level >= DEPTH-HOLD_MARGIN, low the cycle after level drops below it.
REQ-022 FSM states: IDLE, PREFILL, STREAM.
REQ-023 IDLE -> PREFILL on phy_tx_start; this clears underrun, overflow and done_seen.
REQ-024 PREFILL -> STREAM when level >= prefill_thresh, or when done_seen is set (short packet); the rate counter loads 0 on entry.
REQ-025 done_seen latches on phy_tx_done in PREFILL or STREAM.
REQ-026 Rate counter counts 0..max(rate_div,1)-1 and wraps; a tick occurs at the wrap.
REQ-027 Output latency: dac_valid/dac_i/dac_q are registered, one clock after the tick.
REQ-028 STREAM tick with level==0 and done_seen clear: dac_valid=1, dac_i=dac_q=0, set underrun, stay in STREAM.
REQ-029 STREAM with done_seen set and level==0 after the final read: -> IDLE and pulse tx_iq_done for one clock; the pulse must not coincide with the final dac_valid.
REQ-030 phy_tx_start outside IDLE: ignored.
REQ-031 Writes are accepted in every state, including IDLE.

Reset
REQ-032 Asserting reset forces the FSM to IDLE, clears pointers, level and counters, and drives all outputs low/zero (including result_iq_hold and both flags).
REQ-033 Reset asserted mid-packet discards the FIFO contents.
REQ-034 After release, the first action occurs on the first rising clk edge.

Structure
REQ-035 A shared package holds the FSM state encoding, the IQ word width (32) and the DEPTH/HOLD_MARGIN defaults.
REQ-036 One sub-module, tx_iq_fifo_mem: simple dual-port storage with registered read.
REQ-037 FSM, rate counter, level tracking and hold logic live in tx_iq_buf.

Verification
REQ-038 Setup: rate_div=5, prefill_thresh=16, 100 contiguous samples then done. Required: first dac_valid follows the 16th write by 2 clocks; 100 dac_valid strobes spaced exactly 5 clocks; data in order; tx_iq_done once; no flags.
REQ-039 Setup: rate_div=1, producer ignores hold and writes 70 back-to-back samples. Required: hold high once level reaches 60; overflow set; level never exceeds 64.
REQ-040 Setup: prefill_thresh=16, producer stalls at 20 samples with no done. Required: after 20 outputs, zero-valued dac_valid strobes and underrun=1.
REQ-041 Setup: 3-sample packet with prefill_thresh=16. Required: done forces STREAM; 3 outputs, then tx_iq_done.
REQ-042 Setup: reset pulsed at level 30 during STREAM. Required: next clock shows level=0, IDLE, dac_valid=0, hold=0.
REQ-043 Setup: rate_div=0 vs rate_div=1. Required: identical output timing.

Source files
------------

// File: rtl/tx_iq_buf_pkg.sv
// -----------------------------------------------------------------------------
// tx_iq_buf_pkg
// Shared definitions for the TX IQ sample buffer: FSM state encoding, sample
// and IQ word widths, port widths and the default FIFO geometry.
// -----------------------------------------------------------------------------
package tx_iq_buf_pkg;

   localparam int SAMPLE_W        = 16;            // one I or Q component
   localparam int IQ_W            = 32;            // stored word {i, q}
   localparam int LEVEL_W         = 7;             // fifo_level port width
   localparam int RATE_W          = 8;             // rate_div / rate counter width
   localparam int THRESH_W        = 7;             // prefill_thresh port width
   localparam int DEPTH_DEF       = 64;            // FIFO depth in IQ samples
   localparam int HOLD_MARGIN_DEF = 4;             // entries reserved for in-flight samples

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_STREAM  = 2'd2
   } tx_state_e;

   // Packs one producer sample into a FIFO word, I in the upper half.
   function automatic logic [IQ_W-1:0] pack_iq(input logic [SAMPLE_W-1:0] i_val,
                                               input logic [SAMPLE_W-1:0] q_val);
      return {i_val, q_val};
   endfunction

endpackage

// File: rtl/tx_iq_buf_if.sv
// -----------------------------------------------------------------------------
// tx_iq_buf_if
// Bundles the producer side (start/done/sample strobe/hold), the configuration
// inputs and the DAC/status side of tx_iq_buf.
//   master : driven by the producer / control logic
//   slave  : the buffer itself
// -----------------------------------------------------------------------------
interface tx_iq_buf_if;
   import tx_iq_buf_pkg::*;

   // producer side
   logic                       phy_tx_start;
   logic                       phy_tx_done;
   logic                       result_iq_valid;
   logic signed [SAMPLE_W-1:0] result_i;
   logic signed [SAMPLE_W-1:0] result_q;
   logic                       result_iq_hold;
   // configuration
   logic [RATE_W-1:0]          rate_div;
   logic [THRESH_W-1:0]        prefill_thresh;
   // DAC side and status
   logic                       dac_valid;
   logic [SAMPLE_W-1:0]        dac_i;
   logic [SAMPLE_W-1:0]        dac_q;
   logic [LEVEL_W-1:0]         fifo_level;
   logic                       underrun;
   logic                       overflow;
   logic                       tx_iq_done;

   modport master (
      output phy_tx_start, phy_tx_done, result_iq_valid, result_i, result_q,
             rate_div, prefill_thresh,
      input  result_iq_hold, dac_valid, dac_i, dac_q, fifo_level,
             underrun, overflow, tx_iq_done
   );

   modport slave (
      input  phy_tx_start, phy_tx_done, result_iq_valid, result_i, result_q,
             rate_div, prefill_thresh,
      output result_iq_hold, dac_valid, dac_i, dac_q, fifo_level,
             underrun, overflow, tx_iq_done
   );

endinterface

// File: rtl/tx_iq_fifo_mem.sv
// -----------------------------------------------------------------------------
// tx_iq_fifo_mem
// Simple dual-port sample storage: one synchronous write port and one read
// port whose data is registered.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (read register only)
//   wr_en_i/addr/data   write port
//   rd_en_i, rd_addr_i  read request; data appears on rd_data_o next clock
//   rd_clr_i            loads zero into the read register (starved DAC tick)
//   rd_data_o           registered read data
// -----------------------------------------------------------------------------
module tx_iq_fifo_mem
   import tx_iq_buf_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en_i,
   input  logic [AW-1:0]   wr_addr_i,
   input  logic [IQ_W-1:0] wr_data_i,
   input  logic            rd_en_i,
   input  logic            rd_clr_i,
   input  logic [AW-1:0]   rd_addr_i,
   output logic [IQ_W-1:0] rd_data_o
);

   logic [IQ_W-1:0] mem_q [DEPTH];
   logic [IQ_W-1:0] rd_data_q;

   // Storage array write; contents are not reset, occupancy is tracked outside.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read port; a clear takes priority so a starved tick outputs zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= {IQ_W{1'b0}};
      end else if (rd_clr_i) begin
         rd_data_q <= {IQ_W{1'b0}};
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tx_iq_buf.sv
// -----------------------------------------------------------------------------
// tx_iq_buf
// Elastic buffer between an IQ sample producer and a DAC running at a
// programmable sample rate. Samples are prefilled up to a threshold, then
// streamed out one per rate tick; underrun/overflow are flagged (sticky) and
// backpressure is raised when only HOLD_MARGIN free entries remain.
// Ports:
//   clk            single clock
//   phy_tx_arestn  asynchronous active-low reset
//   bus            tx_iq_buf_if.slave: producer strobes/data, hold, rate_div,
//                  prefill_thresh, DAC strobe/data, fifo_level, flags, done
// -----------------------------------------------------------------------------
module tx_iq_buf
   import tx_iq_buf_pkg::*;
#(
   parameter int DEPTH       = DEPTH_DEF,
   parameter int HOLD_MARGIN = HOLD_MARGIN_DEF
) (
   input  logic        clk,
   input  logic        phy_tx_arestn,
   tx_iq_buf_if.slave  bus
);

   localparam int            AW       = $clog2(DEPTH);
   localparam int            LW       = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] HOLD_LVL = LW'(DEPTH - HOLD_MARGIN);

   tx_state_e         state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
   logic [RATE_W-1:0] rate_max_s;
   logic              done_seen_q, done_seen_d;
   logic              underrun_q, underrun_d;
   logic              overflow_q, overflow_d;
   logic              hold_q, hold_d;
   logic              dac_valid_q, dac_valid_d;
   logic              tx_done_q, tx_done_d;
   logic              full_s, empty_s, tick_s;
   logic              wr_en_s, rd_en_s, starve_s;
   logic [IQ_W-1:0]   rd_data_s;

   // Datapath strobes plus pointer, level, hold and DAC-strobe next state.
   always_comb begin
      // rate_div of 0 and 1 both mean one sample per clock
      rate_max_s = (bus.rate_div <= 8'd1) ? 8'd1 : bus.rate_div;
      full_s     = (level_q == FULL_LVL);
      empty_s    = (level_q == {LW{1'b0}});
      // The counter sits at 0 right after each wrap; that cycle is the tick.
      tick_s     = (state_q == ST_STREAM) && (rate_cnt_q == 8'd0);
      wr_en_s    = bus.result_iq_valid && !full_s;
      rd_en_s    = tick_s && !empty_s;
      // Starved tick mid-packet: emit a zero sample. After done it is just the end.
      starve_s   = tick_s && empty_s && !done_seen_q;

      wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = rd_en_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

      case ({wr_en_s, rd_en_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      hold_d      = (level_q >= HOLD_LVL);
      dac_valid_d = rd_en_s || starve_s;
   end

   // Packet FSM, rate counter and sticky status flags.
   always_comb begin
      state_d     = state_q;
      rate_cnt_d  = rate_cnt_q;
      done_seen_d = done_seen_q;
      underrun_d  = underrun_q;
      overflow_d  = overflow_q || (bus.result_iq_valid && full_s);
      tx_done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.phy_tx_start) begin
               state_d     = ST_PREFILL;
               underrun_d  = 1'b0;
               overflow_d  = 1'b0;
               done_seen_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PREFILL: begin
            if (bus.phy_tx_done) begin
               done_seen_d = 1'b1;
            end else begin
               done_seen_d = done_seen_q;
            end
            // A packet shorter than the threshold is released by done.
            if ((32'(level_q) >= 32'(bus.prefill_thresh)) || done_seen_q) begin
               state_d    = ST_STREAM;
               rate_cnt_d = 8'd0;
            end else begin
               state_d = ST_PREFILL;
            end
         end
         ST_STREAM: begin
            if (bus.phy_tx_done) begin
               done_seen_d = 1'b1;
            end else begin
               done_seen_d = done_seen_q;
            end
            // >= guards against rate_div being lowered mid-packet
            if (rate_cnt_q >= (rate_max_s - 8'd1)) begin
               rate_cnt_d = 8'd0;
            end else begin
               rate_cnt_d = rate_cnt_q + 8'd1;
            end
            if (starve_s) begin
               underrun_d = 1'b1;
            end else begin
               underrun_d = underrun_q;
            end
            // Empty after done: the final sample left on an earlier tick, so the
            // done pulse lands one clock after the last dac_valid.
            if (done_seen_q && empty_s) begin
               state_d    = ST_IDLE;
               tx_done_d  = 1'b1;
               rate_cnt_d = 8'd0;
            end else begin
               state_d = ST_STREAM;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, pointer, level and output registers.
   always_ff @(posedge clk or negedge phy_tx_arestn) begin
      if (!phy_tx_arestn) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         level_q     <= {LW{1'b0}};
         rate_cnt_q  <= 8'd0;
         done_seen_q <= 1'b0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
         hold_q      <= 1'b0;
         dac_valid_q <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         rate_cnt_q  <= rate_cnt_d;
         done_seen_q <= done_seen_d;
         underrun_q  <= underrun_d;
         overflow_q  <= overflow_d;
         hold_q      <= hold_d;
         dac_valid_q <= dac_valid_d;
         tx_done_q   <= tx_done_d;
      end
   end

   tx_iq_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .rst_n     (phy_tx_arestn),
      .wr_en_i   (wr_en_s),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (pack_iq(bus.result_i, bus.result_q)),
      .rd_en_i   (rd_en_s),
      .rd_clr_i  (starve_s),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data_s)
   );

   assign bus.result_iq_hold = hold_q;
   assign bus.dac_valid      = dac_valid_q;
   assign bus.dac_i          = rd_data_s[IQ_W-1:SAMPLE_W];
   assign bus.dac_q          = rd_data_s[SAMPLE_W-1:0];
   assign bus.fifo_level     = LEVEL_W'(level_q);
   assign bus.underrun       = underrun_q;
   assign bus.overflow       = overflow_q;
   assign bus.tx_iq_done     = tx_done_q;

endmodule

// File: tb/tb_tx_iq_buf.sv
// -----------------------------------------------------------------------------
// tb_tx_iq_buf
// Directed bench for tx_iq_buf: a scoreboard queue receives every sample the
// producer writes (and the buffer accepts); samples are popped and compared as
// dac_valid strobes appear. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tx_iq_buf;
   import tx_iq_buf_pkg::*;

   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic phy_tx_arestn;

   tx_iq_buf_if bus ();

   tx_iq_buf #(
      .DEPTH       (DEPTH),
      .HOLD_MARGIN (4)
   ) dut (
      .clk           (clk),
      .phy_tx_arestn (phy_tx_arestn),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [31:0] exp_q [$];
   int          n_valid, n_zero, n_done;
   int          first_valid_cyc, last_valid_cyc, last_done_cyc, exp_spacing;
   logic [31:0] d;
   int          mark, s_cyc, sent, guard;
   bit          hit;
   int          off_first [2];
   int          off_done  [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clear_stats(input int spacing);
      n_valid         = 0;
      n_zero          = 0;
      n_done          = 0;
      first_valid_cyc = -1;
      last_valid_cyc  = -1;
      last_done_cyc   = -1;
      exp_spacing     = spacing;
   endtask

   // One clock: wait for the falling edge, then score whatever the DUT shows.
   task automatic cycle();
      logic [31:0] e;
      @(negedge clk);
      cyc++;
      if (bus.dac_valid === 1'b1) begin
         n_valid++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         if (exp_spacing > 0 && last_valid_cyc >= 0)
            chk("strobe_spacing", 32'(cyc - last_valid_cyc), 32'(exp_spacing));
         last_valid_cyc = cyc;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dac_data", {bus.dac_i, bus.dac_q}, e);
         end else begin
            n_zero++;
            chk("underrun_data", {bus.dac_i, bus.dac_q}, 32'h0);
            chk("underrun_flag", 32'(bus.underrun), 32'd1);
         end
      end
      if (bus.tx_iq_done === 1'b1) begin
         n_done++;
         last_done_cyc = cyc;
         chk("done_apart_from_valid", 32'(bus.dac_valid), 32'd0);
      end
      chk("level_bound", 32'(bus.fifo_level > 7'd64), 32'd0);
   endtask

   task automatic drive_sample();
      d                   = $urandom();
      bus.result_iq_valid = 1'b1;
      bus.result_i        = d[31:16];
      bus.result_q        = d[15:0];
   endtask

   // Writes n samples, one per clock unless hold is honoured and high.
   task automatic produce(input int n, input bit obey_hold, input int mark_k, output int mark_cyc);
      int cnt = 0;
      int g   = 0;
      mark_cyc = -1;
      while (cnt < n && g < 4000) begin
         g++;
         if (!obey_hold || bus.result_iq_hold !== 1'b1) begin
            drive_sample();
            exp_q.push_back(d);
            if (cnt == mark_k) mark_cyc = cyc + 1;
            cnt++;
         end else begin
            bus.result_iq_valid = 1'b0;
         end
         cycle();
      end
      bus.result_iq_valid = 1'b0;
      chk("produce_count", 32'(cnt), 32'(n));
   endtask

   task automatic pulse_start();
      bus.phy_tx_start = 1'b1;
      cycle();
      bus.phy_tx_start = 1'b0;
   endtask

   task automatic pulse_done();
      bus.phy_tx_done = 1'b1;
      cycle();
      bus.phy_tx_done = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while (n_done == 0 && k < bound) begin
         cycle();
         k++;
      end
      chk("done_within_bound", 32'(n_done > 0), 32'd1);
      repeat (3) cycle();
   endtask

   initial begin
      bus.phy_tx_start    = 1'b0;
      bus.phy_tx_done     = 1'b0;
      bus.result_iq_valid = 1'b0;
      bus.result_i        = 16'sd0;
      bus.result_q        = 16'sd0;
      bus.rate_div        = 8'd1;
      bus.prefill_thresh  = 7'd16;
      phy_tx_arestn       = 1'b0;
      clear_stats(0);

      // ---- reset state ----
      repeat (3) @(negedge clk);
      chk("rst_level",    32'(bus.fifo_level), 32'd0);
      chk("rst_hold",     32'(bus.result_iq_hold), 32'd0);
      chk("rst_valid",    32'(bus.dac_valid), 32'd0);
      chk("rst_data",     {bus.dac_i, bus.dac_q}, 32'h0);
      chk("rst_underrun", 32'(bus.underrun), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_done",     32'(bus.tx_iq_done), 32'd0);
      phy_tx_arestn = 1'b1;

      // ---- 100-sample packet, rate 5, prefill 16 ----
      bus.rate_div       = 8'd5;
      bus.prefill_thresh = 7'd16;
      clear_stats(5);
      pulse_start();
      produce(100, 1'b1, 15, mark);
      pulse_done();
      repeat (10) cycle();
      pulse_start();                      // mid-stream start must be ignored
      wait_done(2000);
      chk("t1_first_latency", 32'(first_valid_cyc - mark), 32'd2);
      chk("t1_n_valid",       32'(n_valid), 32'd100);
      chk("t1_queue_empty",   32'(exp_q.size()), 32'd0);
      chk("t1_n_done",        32'(n_done), 32'd1);
      chk("t1_n_zero",        32'(n_zero), 32'd0);
      chk("t1_underrun",      32'(bus.underrun), 32'd0);
      chk("t1_overflow",      32'(bus.overflow), 32'd0);

      // ---- 70 back-to-back writes in IDLE, hold ignored ----
      bus.rate_div = 8'd1;
      clear_stats(1);
      for (int k = 1; k <= 70; k++) begin
         drive_sample();
         if (k <= DEPTH) exp_q.push_back(d);
         cycle();
         chk("t2_level",    32'(bus.fifo_level), 32'((k < DEPTH) ? k : DEPTH));
         chk("t2_hold",     32'(bus.result_iq_hold), 32'((k - 1) >= 60));
         chk("t2_overflow", 32'(bus.overflow), 32'(k > DEPTH));
      end
      bus.result_iq_valid = 1'b0;
      chk("t2_no_output_idle", 32'(n_valid), 32'd0);
      pulse_start();
      chk("t2_overflow_cleared", 32'(bus.overflow), 32'd0);
      pulse_done();
      wait_done(500);
      chk("t2_n_valid",     32'(n_valid), 32'd64);
      chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("t2_n_done",      32'(n_done), 32'd1);
      chk("t2_hold_low",    32'(bus.result_iq_hold), 32'd0);

      // ---- producer stalls after 20 samples: underrun ----
      bus.rate_div = 8'd2;
      clear_stats(2);
      pulse_start();
      produce(20, 1'b1, -1, mark);
      guard = 0;
      while (n_zero < 3 && guard < 300) begin
         cycle();
         guard++;
      end
      chk("t3_zero_strobes", 32'(n_zero >= 3), 32'd1);
      chk("t3_data_first",   32'(n_valid - n_zero), 32'd20);
      chk("t3_underrun",     32'(bus.underrun), 32'd1);
      pulse_done();
      wait_done(100);
      chk("t3_n_done",         32'(n_done), 32'd1);
      chk("t3_underrun_stick", 32'(bus.underrun), 32'd1);

      // ---- 3-sample packet below threshold ----
      bus.rate_div = 8'd3;
      clear_stats(3);
      pulse_start();
      chk("t4_flag_cleared", 32'(bus.underrun), 32'd0);
      produce(3, 1'b1, -1, mark);
      pulse_done();
      wait_done(200);
      chk("t4_n_valid",     32'(n_valid), 32'd3);
      chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("t4_n_done",      32'(n_done), 32'd1);
      chk("t4_underrun",    32'(bus.underrun), 32'd0);

      // ---- rate_div 1 and 0 give the same timing ----
      bus.prefill_thresh = 7'd4;
      for (int r = 0; r < 2; r++) begin
         bus.rate_div = (r == 0) ? 8'd1 : 8'd0;
         clear_stats(1);
         s_cyc = cyc;
         pulse_start();
         produce(10, 1'b1, -1, mark);
         pulse_done();
         wait_done(200);
         off_first[r] = first_valid_cyc - s_cyc;
         off_done[r]  = last_done_cyc - s_cyc;
         chk("t5_first_offset", 32'(off_first[r]), 32'd7);
         chk("t5_n_valid",      32'(n_valid), 32'd10);
      end
      chk("t5_done_same", 32'(off_done[1]), 32'(off_done[0]));

      // ---- reset while streaming at level 30 ----
      bus.rate_div       = 8'd5;
      bus.prefill_thresh = 7'd16;
      clear_stats(5);
      pulse_start();
      hit   = 1'b0;
      sent  = 0;
      guard = 0;
      while (!hit && guard < 200) begin
         guard++;
         if (sent < 40 && bus.result_iq_hold !== 1'b1) begin
            drive_sample();
            exp_q.push_back(d);
            sent++;
         end else begin
            bus.result_iq_valid = 1'b0;
         end
         cycle();
         if (bus.fifo_level == 7'd30) hit = 1'b1;
      end
      chk("t6_reached_30", 32'(hit), 32'd1);
      bus.result_iq_valid = 1'b0;
      phy_tx_arestn       = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_level",    32'(bus.fifo_level), 32'd0);
      chk("t6_valid",    32'(bus.dac_valid), 32'd0);
      chk("t6_hold",     32'(bus.result_iq_hold), 32'd0);
      chk("t6_underrun", 32'(bus.underrun), 32'd0);
      chk("t6_overflow", 32'(bus.overflow), 32'd0);
      exp_q.delete();
      @(negedge clk);
      phy_tx_arestn = 1'b1;
      clear_stats(5);
      // back in IDLE: writes are stored but nothing streams without a start
      produce(20, 1'b1, -1, mark);
      repeat (30) cycle();
      chk("t6_idle_no_valid", 32'(n_valid), 32'd0);
      chk("t6_idle_level",    32'(bus.fifo_level), 32'd20);
      pulse_start();
      pulse_done();
      wait_done(300);
      chk("t6_n_valid",     32'(n_valid), 32'd20);
      chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("t6_n_done",      32'(n_done), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
